// File: rtl/traffic_pkg.sv
// Shared state encodings and lamp decode for the two-road traffic sequencer.
// Lamp vectors are ordered {g1,y1,r1,g2,y2,r2,d}.
package traffic_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ALLRED_A = 3'd0;
  localparam state_t GREEN1   = 3'd1;
  localparam state_t YELLOW1  = 3'd2;
  localparam state_t ALLRED_B = 3'd3;
  localparam state_t GREEN2   = 3'd4;
  localparam state_t YELLOW2  = 3'd5;

  localparam logic [6:0] L_ALLRED_A = 7'b0010011;
  localparam logic [6:0] L_GREEN1   = 7'b1000011;
  localparam logic [6:0] L_YELLOW1  = 7'b0100010;
  localparam logic [6:0] L_ALLRED_B = 7'b0010010;
  localparam logic [6:0] L_GREEN2   = 7'b0011000;
  localparam logic [6:0] L_YELLOW2  = 7'b0010101;

  function automatic logic [6:0] state_lights(state_t s);
    logic [6:0] l;
    case (s)
      GREEN1:   l = L_GREEN1;
      YELLOW1:  l = L_YELLOW1;
      ALLRED_B: l = L_ALLRED_B;
      GREEN2:   l = L_GREEN2;
      YELLOW2:  l = L_YELLOW2;
      default:  l = L_ALLRED_A;
    endcase
    return l;
  endfunction

  function automatic state_t next_state(state_t s);
    state_t n;
    case (s)
      ALLRED_A: n = GREEN1;
      GREEN1:   n = YELLOW1;
      YELLOW1:  n = ALLRED_B;
      ALLRED_B: n = GREEN2;
      GREEN2:   n = YELLOW2;
      default:  n = ALLRED_A;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/traffic_seq_tick.sv
// Phase-timing prescaler: tick is high for one enabled cycle out of CLK_DIV.
// The count freezes while en is low and resumes where it stopped.
module traffic_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(CLK_DIV - 1));
  assign tick = en & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_seq.sv
// Two-road traffic-light sequencer: FSM, dwell counter and side-road request
// latch. Lamps, direction flag and phase strobe are all registered.
module traffic_seq
  import traffic_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int T_GREEN  = 5,
  parameter int T_YELLOW = 2,
  parameter int T_ALLRED = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic car2,
  output logic g1,
  output logic y1,
  output logic r1,
  output logic g2,
  output logic y2,
  output logic r2,
  output logic d,
  output logic phase_strobe
);

  localparam int TGY  = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int TMAX = (TGY > T_ALLRED) ? TGY : T_ALLRED;
  localparam int DW   = $clog2(TMAX + 1);

  logic          tick;
  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d, dwell_last;
  logic          req_q, req_d;
  logic [6:0]    lights_q, lights_d;
  logic          strobe_q, strobe_d;
  logic          legal;

  traffic_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  always_comb begin
    dwell_last = '0;
    case (state_q)
      GREEN1, GREEN2:   dwell_last = DW'(T_GREEN - 1);
      YELLOW1, YELLOW2: dwell_last = DW'(T_YELLOW - 1);
      default:          dwell_last = DW'(T_ALLRED - 1);
    endcase
  end

  assign legal = (state_q <= YELLOW2);

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    req_d   = req_q;
    if (!legal) begin
      state_d = ALLRED_A;
      dwell_d = '0;
    end else if (tick) begin
      if (dwell_q == dwell_last) begin
        // road 1 rests on green, dwell saturated, until a request shows up
        if (state_q != GREEN1 || req_q || car2) begin
          state_d = next_state(state_q);
          dwell_d = '0;
        end
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
    if (en && car2 && state_q != GREEN2) req_d = 1'b1;
    if (state_d == GREEN2 && state_q != GREEN2) req_d = 1'b0;
  end

  assign lights_d = state_lights(state_d);
  assign strobe_d = (state_d != state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ALLRED_A;
      dwell_q  <= '0;
      req_q    <= 1'b0;
      lights_q <= L_ALLRED_A;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      req_q    <= req_d;
      lights_q <= lights_d;
      strobe_q <= strobe_d;
    end
  end

  assign {g1, y1, r1, g2, y2, r2, d} = lights_q;
  assign phase_strobe = strobe_q;

endmodule

// File: tb/tb_traffic_seq.sv
// Bench for traffic_seq: phase-length table, directed corner sequences and
// randomized en/car2 against a tick-counting phase model.
module tb_traffic_seq;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;
  logic car2 = 1'b0;

  wire [6:0] la;
  wire       sa;
  wire [6:0] lb;
  wire       sb;

  traffic_seq dut (
    .clk(clk), .rst(rst), .en(en), .car2(car2),
    .g1(la[6]), .y1(la[5]), .r1(la[4]),
    .g2(la[3]), .y2(la[2]), .r2(la[1]),
    .d(la[0]), .phase_strobe(sa)
  );

  traffic_seq #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .car2(car2),
    .g1(lb[6]), .y1(lb[5]), .r1(lb[4]),
    .g2(lb[3]), .y2(lb[2]), .r2(lb[1]),
    .d(lb[0]), .phase_strobe(sb)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] AA = 7'b0010011;
  localparam logic [6:0] G1 = 7'b1000011;
  localparam logic [6:0] Y1 = 7'b0100010;
  localparam logic [6:0] AB = 7'b0010010;
  localparam logic [6:0] G2 = 7'b0011000;
  localparam logic [6:0] Y2 = 7'b0010101;

  logic [6:0] lt [6];
  initial begin
    lt[0] = AA; lt[1] = G1; lt[2] = Y1;
    lt[3] = AB; lt[4] = G2; lt[5] = Y2;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // phase model: phases 0..5, ticks counted since entry
  typedef struct {
    int ph;
    int ticks;
    int ecnt;
    bit req;
    bit strobe;
  } mdl_t;

  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};

  function automatic int tlen(int ph);
    case (ph)
      0, 3:    return 1;
      1, 4:    return 5;
      default: return 2;
    endcase
  endfunction

  function automatic mdl_t mstep(mdl_t m, int div, bit en_i, bit car_i);
    mdl_t n;
    int nxt;
    n = m;
    n.strobe = 0;
    if (!en_i) return n;
    nxt = m.ph;
    if ((m.ecnt % div) == div - 1) begin
      n.ticks = m.ticks + 1;
      if (m.ph == 1) begin
        if (n.ticks >= 5 && (m.req || car_i)) nxt = 2;
      end else if (n.ticks >= tlen(m.ph)) begin
        nxt = (m.ph + 1) % 6;
      end
    end
    n.ecnt = m.ecnt + 1;
    if (car_i && m.ph != 4) n.req = 1;
    if (nxt == 4 && m.ph != 4) n.req = 0;
    if (nxt != m.ph) begin
      n.ph = nxt;
      n.ticks = 0;
      n.strobe = 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = mstep(ma, 4, en, car2);
      mb = mstep(mb, 1, en, car2);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_div4", {24'd0, la, sa}, {24'd0, lt[ma.ph], ma.strobe});
      chk("model_div1", {24'd0, lb, sb}, {24'd0, lt[mb.ph], mb.strobe});
      chk("onehot_r1_div4", 32'($onehot(la[6:4])), 1);
      chk("onehot_r2_div4", 32'($onehot(la[3:1])), 1);
      chk("onehot_r1_div1", 32'($onehot(lb[6:4])), 1);
      chk("onehot_r2_div1", 32'($onehot(lb[3:1])), 1);
      chk("noconflict_div4", 32'(la[4] | la[1]), 1);
      chk("noconflict_div1", 32'(lb[4] | lb[1]), 1);
    end
  end

  typedef struct {
    int         div;
    int         len;
    logic [6:0] lights;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [7:0] outv(int div);
    return (div == 4) ? {la, sa} : {lb, sb};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_l(input logic [6:0] l, input int bound,
                        input string nm);
    int n = 0;
    while (la !== l && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(la === l), 1);
  endtask

  task automatic run_table(input int div);
    int  cnt;
    int  sum = 0;
    bit  first = 1;
    logic [7:0] o;
    en = 1'b1;
    car2 = 1'b1;
    do_reset();
    chk("reset_state", {24'd0, outv(div)}, {24'd0, AA, 1'b0});
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].div == div) begin
        if (!first) chk($sformatf("strobe_%0d", i), 32'(outv(div)), 
                        {24'd0, tbl[i].lights, 1'b1});
        first = 0;
        cnt = 0;
        o = outv(div);
        while (o[7:1] === tbl[i].lights && cnt < 200) begin
          @(negedge clk);
          cnt++;
          o = outv(div);
        end
        chk($sformatf("len_%0d", i), 32'(cnt), 32'(tbl[i].len));
        sum += cnt;
      end
    end
    chk($sformatf("period_div%0d", div), 32'(sum), (div == 4) ? 64 : 16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int strobes;
    int bad;
    tbl[0]  = '{4, 4,  AA};
    tbl[1]  = '{4, 20, G1};
    tbl[2]  = '{4, 8,  Y1};
    tbl[3]  = '{4, 4,  AB};
    tbl[4]  = '{4, 20, G2};
    tbl[5]  = '{4, 8,  Y2};
    tbl[6]  = '{1, 1,  AA};
    tbl[7]  = '{1, 5,  G1};
    tbl[8]  = '{1, 2,  Y1};
    tbl[9]  = '{1, 1,  AB};
    tbl[10] = '{1, 5,  G2};
    tbl[11] = '{1, 2,  Y2};

    repeat (3) @(negedge clk);
    run_table(4);
    run_table(1);

    // rest on green with no side traffic
    car2 = 1'b0;
    do_reset();
    wait_l(G1, 10, "reach_g1");
    strobes = 0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sa) strobes++;
      if (la !== G1) bad++;
    end
    chk("g1_rest_strobes", 32'(strobes), 0);
    chk("g1_rest_lamps", 32'(bad), 0);
    car2 = 1'b1;
    @(negedge clk);
    car2 = 1'b0;
    cnt = 1;
    while (la === G1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("y1_after_pulse", 32'(la === Y1 && cnt <= 4), 1);

    // request latched during YELLOW2 carries into GREEN1
    wait_l(Y2, 100, "reach_y2");
    car2 = 1'b1;
    @(negedge clk);
    car2 = 1'b0;
    wait_l(G1, 40, "reach_g1_latched");
    cnt = 0;
    while (la === G1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("g1_latched_len", 32'(cnt), 20);

    // car2 during GREEN2 is ignored
    wait_l(G2, 60, "reach_g2");
    car2 = 1'b1;
    @(negedge clk);
    car2 = 1'b0;
    wait_l(G1, 60, "reach_g1_ignored");
    cnt = 0;
    while (la === G1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("g1_holds_after_g2_pulse", 32'(cnt), 300);

    // en dropped for 10 cycles mid-GREEN2
    car2 = 1'b1;
    @(negedge clk);
    car2 = 1'b0;
    wait_l(G2, 60, "reach_g2_freeze");
    cnt = 0;
    while (la === G2 && cnt < 100) begin
      if (cnt == 6) en = 1'b0;
      if (cnt == 16) en = 1'b1;
      @(negedge clk);
      cnt++;
    end
    chk("g2_freeze_len", 32'(cnt), 30);

    // async reset mid-YELLOW1
    car2 = 1'b1;
    wait_l(Y1, 80, "reach_y1");
    car2 = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async_reset", {24'd0, la, sa}, {24'd0, AA, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (la === AA && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("g1_after_reset", 32'(cnt), 4);
    chk("g1_after_reset_lamps", {24'd0, la, sa}, {24'd0, G1, 1'b1});

    // randomized enable and sensor activity
    do_reset();
    repeat (3000) begin
      en   = ($urandom % 8) != 0;
      car2 = ($urandom % 6) == 0;
      @(negedge clk);
    end
    en = 1'b1;
    car2 = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
